// File: rtl/cpu_pkg.sv
// Shared CPU register-file types and helpers.
// No logic; constants and a width helper only.
// No flow control.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Architectural register that always reads zero when the zero-register option is on
  localparam int REG_ZERO = 0;

  // Bits needed to count 0..max_inflight outstanding writes
  function automatic int cnt_w(input int max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Per-register in-flight write counter: +1 on issue, -1 on retire, saturating at MAX_INFLIGHT.
// Count updates on the next clock edge; at_max/underflow are combinational from current state.
// No backpressure of its own; issue gating against at_max is done by the register file.
module sb_counter
  import cpu_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = cnt_w(MAX_INFLIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  assign at_max    = (cnt == CNT_MAX);
  // A retire with nothing outstanding is a pipeline bookkeeping error
  assign underflow = dec && !inc && (cnt == '0);

  // Simultaneous issue and retire cancel; retire at zero holds the count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && !dec && !at_max) begin
      cnt <= cnt + CNT_ONE;
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with NUM_RD combinational read ports, one WB write port, bypass and in-flight scoreboard.
// Reads are 0-latency (same-cycle WB data bypassed); writes and scoreboard updates land at the next edge.
// issue_ok drops when the destination already has MAX_INFLIGHT writes pending; ID must hold and retry.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int NUM_RD       = 2,
  parameter int MAX_INFLIGHT = 3,
  parameter int ZERO_REG     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_waddr,
  output logic                     issue_ok,
  input  logic                     wen,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  output logic                     sb_err
);

  localparam int NREG  = 2 ** ADDR_W;
  localparam int CNT_W = cnt_w(MAX_INFLIGHT);
  localparam bit ZR    = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] ZADDR   = ADDR_W'(REG_ZERO);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  cnt  [NREG];
  logic [NREG-1:0]   at_max;
  logic [NREG-1:0]   under;

  logic wr_ok;
  logic issue_acc;
  logic issue_zero;

  assign wr_ok      = wen && !(ZR && (waddr == ZADDR));
  assign issue_zero = ZR && (issue_waddr == ZADDR);
  // A retire to the same destination frees a slot in the same cycle
  assign issue_ok   = !issue_en || issue_zero || !at_max[issue_waddr] ||
                      (wen && (waddr == issue_waddr));
  assign issue_acc  = issue_en && issue_ok;

  // One scoreboard counter per tracked register; the hard-wired zero register has none
  for (genvar r = 0; r < NREG; r++) begin : g_sb
    if (ZR && (r == REG_ZERO)) begin : g_zero
      assign cnt[r]    = '0;
      assign at_max[r] = 1'b0;
      assign under[r]  = 1'b0;
    end else begin : g_cnt
      sb_counter #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_W        (CNT_W)
      ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (issue_acc && (issue_waddr == ADDR_W'(r))),
        .dec       (wen && (waddr == ADDR_W'(r))),
        .cnt       (cnt[r]),
        .at_max    (at_max[r]),
        .underflow (under[r])
      );
    end
  end

  // Register storage: WB write lands at the edge, reset clears everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: zero register, then WB bypass, then storage; busy unless the last pending write retires now
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic [CNT_W-1:0]  c;

    assign ra  = raddr[p*ADDR_W +: ADDR_W];
    assign hit = wen && (waddr == ra);
    assign c   = cnt[ra];

    assign rdata[p*DATA_W +: DATA_W] = (ZR && (ra == ZADDR)) ? '0 :
                                       hit                   ? wdata :
                                                               regs[ra];
    assign rbusy[p] = (c != '0) && !((c == CNT_ONE) && hit);
  end

  // Sticky bookkeeping error: any retire against an empty count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_err <= 1'b0;
    end else if (|under) begin
      sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, reset-in-flight sequence, random vs reference model.
// Outputs are checked 1 time unit after inputs change, well away from the rising edge.
// No backpressure modelling beyond issue_ok acceptance.
module tb_regfile_scoreboard;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 3;
  localparam int MI   = 3;
  localparam int NREG = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR*AW-1:0]  raddr = '0;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     rbusy;
  logic              issue_en = 1'b0;
  logic [AW-1:0]     issue_waddr = '0;
  logic              issue_ok;
  logic              wen = 1'b0;
  logic [AW-1:0]     waddr = '0;
  logic [DW-1:0]     wdata = '0;
  logic              sb_err;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .NUM_RD       (NR),
    .MAX_INFLIGHT (MI),
    .ZERO_REG     (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .raddr       (raddr),
    .rdata       (rdata),
    .rbusy       (rbusy),
    .issue_en    (issue_en),
    .issue_waddr (issue_waddr),
    .issue_ok    (issue_ok),
    .wen         (wen),
    .waddr       (waddr),
    .wdata       (wdata),
    .sb_err      (sb_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                  wen;
    logic [AW-1:0]         waddr;
    logic [DW-1:0]         wdata;
    logic                  ien;
    logic [AW-1:0]         iaddr;
    logic [NR-1:0][AW-1:0] ra;
    logic [NR-1:0][DW-1:0] erd;
    logic [NR-1:0]         ebusy;
    logic                  eok;
    logic                  eerr;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  // Reference model state
  logic [DW-1:0] mem_m [NREG];
  int            cnt_m [NREG];
  logic          err_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic w, input int wa, input logic [DW-1:0] wd,
                              input logic ie, input int ia,
                              input int a0, input int a1, input int a2,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                              input logic [NR-1:0] eb, input logic ok, input logic er);
    vec_t v;
    v.wen    = w;
    v.waddr  = AW'(wa);
    v.wdata  = wd;
    v.ien    = ie;
    v.iaddr  = AW'(ia);
    v.ra[0]  = AW'(a0);
    v.ra[1]  = AW'(a1);
    v.ra[2]  = AW'(a2);
    v.erd[0] = d0;
    v.erd[1] = d1;
    v.erd[2] = d2;
    v.ebusy  = eb;
    v.eok    = ok;
    v.eerr   = er;
    return v;
  endfunction

  task automatic check_outputs(input string tag, input logic [NR-1:0][DW-1:0] erd,
                               input logic [NR-1:0] eb, input logic ok, input logic er);
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("%s rdata%0d", tag, p), 64'(rdata[p*DW +: DW]), 64'(erd[p]));
    end
    chk({tag, " rbusy"},    64'(rbusy),    64'(eb));
    chk({tag, " issue_ok"}, 64'(issue_ok), 64'(ok));
    chk({tag, " sb_err"},   64'(sb_err),   64'(er));
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      mem_m[r] = '0;
      cnt_m[r] = 0;
    end
    err_m = 1'b0;
  endtask

  // Checks current outputs against the model, then advances the model by one clock
  task automatic model_step(input string tag);
    logic [NR-1:0][DW-1:0] erd;
    logic [NR-1:0]         eb;
    logic                  eok;
    int                    a;
    int                    pending;
    bit                    inc;
    bit                    dec;
    eok = !issue_en || (issue_waddr == 0) || (cnt_m[issue_waddr] < MI) ||
          (wen && waddr == issue_waddr);
    for (int p = 0; p < NR; p++) begin
      a = int'(raddr[p*AW +: AW]);
      if (a == 0)                   erd[p] = '0;
      else if (wen && waddr == a)   erd[p] = wdata;
      else                          erd[p] = mem_m[a];
      pending = cnt_m[a];
      if (wen && waddr == a && pending > 0) pending--;
      eb[p] = (a != 0) && (pending > 0);
    end
    check_outputs(tag, erd, eb, eok, err_m);
    if (wen && waddr != 0) mem_m[waddr] = wdata;
    for (int r = 1; r < NREG; r++) begin
      inc = issue_en && eok && (issue_waddr == r);
      dec = wen && (waddr == r);
      if (inc && !dec) cnt_m[r]++;
      else if (dec && !inc) begin
        if (cnt_m[r] == 0) err_m = 1'b1;
        else               cnt_m[r]--;
      end
    end
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 0,            1, 5, 5, 0, 7, 0, 0, 0,                                  3'b000, 1, 0);
    tbl[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 5, 5, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0,            3'b000, 1, 0);
    tbl[2]  = mk(0, 0, 0,            0, 0, 5, 0, 5, 32'hDEADBEEF, 0, 32'hDEADBEEF,            3'b000, 1, 0);
    tbl[3]  = mk(1, 0, 32'h1234,     1, 0, 0, 0, 0, 0, 0, 0,                                  3'b000, 1, 0);
    tbl[4]  = mk(0, 0, 0,            1, 0, 0, 5, 0, 0, 32'hDEADBEEF, 0,                       3'b000, 1, 0);
    tbl[5]  = mk(0, 0, 0,            1, 7, 7, 7, 7, 0, 0, 0,                                  3'b000, 1, 0);
    tbl[6]  = mk(0, 0, 0,            1, 7, 7, 7, 7, 0, 0, 0,                                  3'b111, 1, 0);
    tbl[7]  = mk(0, 0, 0,            1, 7, 7, 7, 7, 0, 0, 0,                                  3'b111, 1, 0);
    tbl[8]  = mk(0, 0, 0,            1, 7, 7, 7, 7, 0, 0, 0,                                  3'b111, 0, 0);
    tbl[9]  = mk(1, 7, 32'h77,       1, 7, 7, 7, 5, 32'h77, 32'h77, 32'hDEADBEEF,             3'b011, 1, 0);
    tbl[10] = mk(1, 7, 32'h78,       0, 0, 7, 7, 7, 32'h78, 32'h78, 32'h78,                   3'b111, 1, 0);
    tbl[11] = mk(1, 7, 32'h79,       0, 0, 7, 7, 7, 32'h79, 32'h79, 32'h79,                   3'b111, 1, 0);
    tbl[12] = mk(1, 7, 32'h7A,       0, 0, 7, 7, 7, 32'h7A, 32'h7A, 32'h7A,                   3'b000, 1, 0);
    tbl[13] = mk(0, 0, 0,            0, 0, 7, 7, 7, 32'h7A, 32'h7A, 32'h7A,                   3'b000, 1, 0);
    tbl[14] = mk(1, 9, 32'h99,       0, 0, 9, 7, 0, 32'h99, 32'h7A, 0,                        3'b000, 1, 0);
    tbl[15] = mk(0, 0, 0,            0, 0, 9, 9, 9, 32'h99, 32'h99, 32'h99,                   3'b000, 1, 1);
    tbl[16] = mk(0, 0, 0,            1, 3, 3, 9, 0, 0, 32'h99, 0,                             3'b000, 1, 1);
    tbl[17] = mk(0, 0, 0,            0, 0, 3, 3, 3, 0, 0, 0,                                  3'b111, 1, 1);

    // Reset state, with an issue pending so issue_ok is meaningful
    rst = 1'b0;
    issue_en = 1'b1;
    issue_waddr = 5'd7;
    raddr = {5'd9, 5'd7, 5'd5};
    #1;
    check_outputs("reset", '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    issue_en = 1'b0;

    // Directed vectors
    for (int i = 0; i < NVEC; i++) begin
      wen         = tbl[i].wen;
      waddr       = tbl[i].waddr;
      wdata       = tbl[i].wdata;
      issue_en    = tbl[i].ien;
      issue_waddr = tbl[i].iaddr;
      for (int p = 0; p < NR; p++) raddr[p*AW +: AW] = tbl[i].ra[p];
      #1;
      check_outputs($sformatf("vec%0d", i), tbl[i].erd, tbl[i].ebusy, tbl[i].eok, tbl[i].eerr);
      @(negedge clk);
    end

    // Reset in the middle of activity: r3 pending, r9 written, sb_err set
    wen = 1'b0;
    issue_en = 1'b1;
    issue_waddr = 5'd3;
    raddr = {5'd3, 5'd7, 5'd9};
    rst = 1'b0;
    #1;
    check_outputs("midreset", '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    issue_en = 1'b0;
    #1;
    check_outputs("post_reset", '0, '0, 1'b1, 1'b0);
    @(negedge clk);

    // Randomised traffic against the reference model
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      waddr       = AW'($urandom_range(0, 7));
      wdata       = $urandom;
      wen         = (cnt_m[waddr] > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 31) == 0);
      issue_en    = 1'($urandom_range(0, 1));
      issue_waddr = AW'($urandom_range(0, 7));
      for (int p = 0; p < NR; p++) raddr[p*AW +: AW] = AW'($urandom_range(0, 7));
      #1;
      model_step("rand");
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
